// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs a debug-unit byte stream big-endian into 32-bit words
// and writes them from address 0 until HALT_WORD or a full memory. Optional trailing
// checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
   parameter int          PC_SIZE   = 32,
   parameter int          MEM_WORDS = 64,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [7:0]         i_byte,
   input  logic               i_byte_valid,
   output logic               o_byte_ready,
   output logic               o_wr_en,
   output logic [PC_SIZE-1:0] o_wr_addr,
   output logic [31:0]        o_wr_data,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overflow
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic               o_cksum_err
`endif
);

   localparam int            AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3
`ifdef LOADER_CHECKSUM_EN
      ,
      CHECK = 3'd4
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [31:0]        word_q, word_d;
   logic               byte_ready_d;
   logic               wr_en_d;
   logic [PC_SIZE-1:0] wr_addr_d;
   logic [31:0]        wr_data_d;
   logic               busy_d, done_d, overflow_d;
   logic               accept;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]         xor_q, xor_d;
   logic               cksum_err_d;
`endif

   assign accept = i_byte_valid & o_byte_ready;

   // Every output is registered, so the output values are computed here from the next state.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      word_d     = word_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = o_wr_addr;
      wr_data_d  = o_wr_data;
      overflow_d = o_overflow;
`ifdef LOADER_CHECKSUM_EN
      xor_d       = xor_q;
      cksum_err_d = o_cksum_err;
`endif

      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               state_d    = RECV;
               cnt_d      = 2'd0;
               addr_d     = '0;
               word_d     = '0;
               overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               xor_d       = 8'h00;
               cksum_err_d = 1'b0;
`endif
            end
         end
         RECV: begin
            if (accept) begin
               word_d = {word_q[23:0], i_byte};
               cnt_d  = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               xor_d  = xor_q ^ i_byte;
`endif
               if (cnt_q == 2'd3) begin
                  state_d               = WRITE;
                  wr_en_d               = 1'b1;
                  wr_data_d             = word_d;
                  wr_addr_d             = '0;
                  wr_addr_d[AW+1:0]     = {addr_q, 2'b00};
               end
            end
         end
         WRITE: begin
            if (word_q == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = DONE;
`endif
            end else if (addr_q == LAST_ADDR) begin
               overflow_d = 1'b1;
               state_d    = DONE;
            end else begin
               addr_d  = addr_q + AW'(1);
               cnt_d   = 2'd0;
               state_d = RECV;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) begin
               cksum_err_d = (i_byte != xor_q);
               state_d     = DONE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      byte_ready_d = (state_d == RECV);
      busy_d       = (state_d == RECV) || (state_d == WRITE);
`ifdef LOADER_CHECKSUM_EN
      byte_ready_d = byte_ready_d || (state_d == CHECK);
      busy_d       = busy_d || (state_d == CHECK);
`endif
      done_d       = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         addr_q       <= '0;
         word_q       <= '0;
         o_byte_ready <= 1'b0;
         o_wr_en      <= 1'b0;
         o_wr_addr    <= '0;
         o_wr_data    <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_q        <= 8'h00;
         o_cksum_err  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         word_q       <= word_d;
         o_byte_ready <= byte_ready_d;
         o_wr_en      <= wr_en_d;
         o_wr_addr    <= wr_addr_d;
         o_wr_data    <= wr_data_d;
         o_busy       <= busy_d;
         o_done       <= done_d;
         o_overflow   <= overflow_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q        <= xor_d;
         o_cksum_err  <= cksum_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: expected writes are queued as words are sent
// and compared (address, data, strobe cycle) when the write strobe appears.
module tb_instr_mem_loader;

   localparam int          PC_SIZE = 32;
   localparam int          MW      = 4;
   localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

   logic               i_clk = 1'b0;
   logic               i_reset;
   logic               i_start;
   logic [7:0]         i_byte;
   logic               i_byte_valid;
   logic               o_byte_ready;
   logic               o_wr_en;
   logic [PC_SIZE-1:0] o_wr_addr;
   logic [31:0]        o_wr_data;
   logic               o_busy;
   logic               o_done;
   logic               o_overflow;
`ifdef LOADER_CHECKSUM_EN
   logic               o_cksum_err;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t         sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [31:0] exp_addr;
   logic [7:0]  sent_xor;
   logic        prev_wr  = 1'b0;

   instr_mem_loader #(.PC_SIZE(PC_SIZE), .MEM_WORDS(MW), .HALT_WORD(HALT)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_byte       (i_byte),
      .i_byte_valid (i_byte_valid),
      .o_byte_ready (o_byte_ready),
      .o_wr_en      (o_wr_en),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_overflow   (o_overflow)
`ifdef LOADER_CHECKSUM_EN
      ,
      .o_cksum_err  (o_cksum_err)
`endif
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // The strobe must be visible in the cycle right after the 4th-byte handshake edge.
   always @(negedge i_clk) begin
      if (o_wr_en) begin
         wr_t e;
         check("wr_en_single", prev_wr, 1'b0);
         check("sb_nonempty", sb_q.size() != 0, 1'b1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("wr_addr", o_wr_addr, e.addr);
            check("wr_data", o_wr_data, e.data);
            check("wr_cycle", cyc, e.cyc);
         end
      end
      prev_wr = o_wr_en;
   end

   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      int   tries = 0;
      do begin
         @(negedge i_clk);
         i_byte       = b;
         i_byte_valid = 1'b1;
         rdy          = o_byte_ready;
         @(posedge i_clk);
         #1;
         tries++;
      end while (!rdy && tries < 20);
      if (!rdy) check("byte_accept_timeout", rdy, 1'b1);
      sent_xor = sent_xor ^ b;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      wr_t e;
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[i*8 +: 8]);
         if (i == 0) begin
            e.addr = exp_addr;
            e.data = w;
            e.cyc  = cyc;
            sb_q.push_back(e);
            exp_addr = exp_addr + 32'd4;
         end
         if (gap) begin
            @(negedge i_clk);
            i_byte_valid = 1'b0;
         end
      end
   endtask

   task automatic finish_cksum();
`ifdef LOADER_CHECKSUM_EN
      send_byte(sent_xor);
`endif
   endtask

   task automatic do_start();
      @(negedge i_clk);
      i_byte_valid = 1'b0;
      i_start      = 1'b1;
      @(negedge i_clk);
      i_start  = 1'b0;
      exp_addr = 32'd0;
      sent_xor = 8'h00;
      check("start_busy", o_busy, 1'b1);
      check("start_ready", o_byte_ready, 1'b1);
      check("start_done_clr", o_done, 1'b0);
      check("start_ovf_clr", o_overflow, 1'b0);
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge i_clk);
      i_byte_valid = 1'b0;
      while (!o_done && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check("done_seen", o_done, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, o_byte_ready, 1'b0);
      check({tag, "_wr_en"}, o_wr_en, 1'b0);
      check({tag, "_wr_addr"}, o_wr_addr, '0);
      check({tag, "_wr_data"}, o_wr_data, '0);
      check({tag, "_busy"}, o_busy, 1'b0);
      check({tag, "_done"}, o_done, 1'b0);
      check({tag, "_ovf"}, o_overflow, 1'b0);
   endtask

   initial begin
      i_reset      = 1'b0;
      i_start      = 1'b0;
      i_byte       = 8'h00;
      i_byte_valid = 1'b0;
      exp_addr     = 32'd0;
      sent_xor     = 8'h00;
      repeat (3) @(negedge i_clk);
      check_all_zero("reset");
      i_reset = 1'b1;

      // Basic program followed by the halt word.
      do_start();
      send_word(32'h2008_0005, 1'b0);
      send_word(HALT, 1'b0);
      finish_cksum();
      wait_done();
      check("basic_ovf", o_overflow, 1'b0);
      check("basic_busy", o_busy, 1'b0);
      check("basic_ready", o_byte_ready, 1'b0);

      // Restart from DONE and fill memory without a halt word.
      do_start();
      for (int i = 0; i < MW; i++) send_word(32'h1011_1213 + i * 32'h0404_0404, 1'b0);
      wait_done();
      check("full_ovf", o_overflow, 1'b1);
      @(negedge i_clk);
      i_byte       = 8'hAA;
      i_byte_valid = 1'b1;
      check("full_ready", o_byte_ready, 1'b0);
      repeat (3) @(negedge i_clk);
      i_byte_valid = 1'b0;
      check("full_done_hold", o_done, 1'b1);
      check("full_busy", o_busy, 1'b0);

      // Reset in the middle of word 1 abandons the load without a write.
      do_start();
      send_word(32'h0102_0304, 1'b0);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(negedge i_clk);
      i_byte_valid = 1'b0;
      i_reset      = 1'b0;
      repeat (2) @(negedge i_clk);
      check_all_zero("midreset");
      i_reset = 1'b1;
      do_start();
      send_word(32'hCAFE_BABE, 1'b0);
      send_word(HALT, 1'b0);
      finish_cksum();
      wait_done();
      check("restart_ovf", o_overflow, 1'b0);

      // Gapped valid, a start pulse while busy, and a halt word in the last location.
      do_start();
      send_word(32'h1122_3344, 1'b1);
      @(negedge i_clk);
      i_byte_valid = 1'b0;
      i_start      = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check("busy_start_busy", o_busy, 1'b1);
      check("busy_start_done", o_done, 1'b0);
      send_word(32'h5566_7788, 1'b1);
      send_word(32'h99AA_BBCC, 1'b1);
      send_word(HALT, 1'b1);
      finish_cksum();
      wait_done();
      check("last_halt_ovf", o_overflow, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      do_start();
      send_word(32'h0000_0000, 1'b0);
      send_word(HALT, 1'b0);
      send_byte(8'h00);
      wait_done();
      check("cksum_good_err", o_cksum_err, 1'b0);
      do_start();
      send_word(32'h0000_0000, 1'b0);
      send_word(HALT, 1'b0);
      send_byte(8'h01);
      wait_done();
      check("cksum_bad_err", o_cksum_err, 1'b1);
`endif

      repeat (3) @(negedge i_clk);
      check("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
